// File: rtl/scan_test_controller_if.sv
// Bus between a scan test requester and scan_test_controller, including the chain taps.
// Define SCAN_CTRL_COMPARE_EN to add the expected_in / pass compare signals.
interface scan_test_controller_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] pattern_in;
    logic                 chain_out;
    logic                 scan_in;
    logic                 scan_en;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] result;
`ifdef SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] expected_in;
    logic                 pass;

    modport master (
        output start, pattern_in, chain_out, expected_in,
        input  scan_in, scan_en, busy, done, result, pass
    );

    modport slave (
        input  start, pattern_in, chain_out, expected_in,
        output scan_in, scan_en, busy, done, result, pass
    );
`else
    modport master (
        output start, pattern_in, chain_out,
        input  scan_in, scan_en, busy, done, result
    );

    modport slave (
        input  start, pattern_in, chain_out,
        output scan_in, scan_en, busy, done, result
    );
`endif
endinterface

// File: rtl/scan_test_controller.sv
// Runs one scan test on an attached chain: shift pattern in, capture once, shift response out.
// Optional feature: define SCAN_CTRL_COMPARE_EN to compare the response against expected_in.
module scan_test_controller #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    scan_test_controller_if.slave bus
);
    localparam int             CW   = $clog2(CHAIN_LEN) + 1;
    localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [CHAIN_LEN-1:0]   pattern_sr;
    logic [CHAIN_LEN-2:0]   shadow;
    logic [CHAIN_LEN-1:0]   shadow_next;
    logic                   scan_in_q;
    logic                   scan_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CHAIN_LEN-1:0]   result_q;
`ifdef SCAN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0]   expected_q;
    logic                   pass_q;
`endif

    // Chain output is taken at the same edge the chain shifts, so the pre-shift bit lands here.
    assign shadow_next = {shadow, bus.chain_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            pattern_sr <= '0;
            shadow     <= '0;
            scan_in_q  <= 1'b0;
            scan_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
`ifdef SCAN_CTRL_COMPARE_EN
            expected_q <= '0;
            pass_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SHIFT_IN;
                        pattern_sr <= {bus.pattern_in[CHAIN_LEN-2:0], 1'b0};
                        scan_in_q  <= bus.pattern_in[CHAIN_LEN-1];
                        scan_en_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        count      <= '0;
`ifdef SCAN_CTRL_COMPARE_EN
                        expected_q <= bus.expected_in;
`endif
                    end
                end
                SHIFT_IN: begin
                    if (count == LAST) begin
                        state     <= CAPTURE;
                        scan_en_q <= 1'b0;
                        scan_in_q <= 1'b0;
                        count     <= '0;
                    end else begin
                        scan_in_q  <= pattern_sr[CHAIN_LEN-1];
                        pattern_sr <= {pattern_sr[CHAIN_LEN-2:0], 1'b0};
                        count      <= count + CW'(1);
                    end
                end
                CAPTURE: begin
                    state     <= SHIFT_OUT;
                    scan_en_q <= 1'b1;
                    scan_in_q <= 1'b0;
                    count     <= '0;
                end
                SHIFT_OUT: begin
                    shadow <= shadow_next[CHAIN_LEN-2:0];
                    if (count == LAST) begin
                        state     <= IDLE;
                        result_q  <= shadow_next;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        scan_en_q <= 1'b0;
                        count     <= '0;
`ifdef SCAN_CTRL_COMPARE_EN
                        pass_q    <= (shadow_next == expected_q);
`endif
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.scan_in = scan_in_q;
    assign bus.scan_en = scan_en_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
`ifdef SCAN_CTRL_COMPARE_EN
    assign bus.pass    = pass_q;
`endif

endmodule

// File: tb/tb_scan_test_controller.sv
// Scoreboard bench for scan_test_controller with a multiplier-capture chain model.
// Accepted tests push their expected response; a negedge monitor pops at the predicted done edge.
module tb_scan_test_controller;
    localparam int N   = 8;
    localparam int LAT = 2 * N + 1;

    typedef struct {
        int         done_edge;
        logic [7:0] res;
        logic       pass_exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_test_controller_if #(.CHAIN_LEN(N)) bus();

    scan_test_controller #(.CHAIN_LEN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Attached chain: shifts when scan_en=1, otherwise captures the 4x4 product of its halves.
    logic [7:0] chain_q = 8'h00;
    always @(posedge clk) begin
        if (bus.scan_en) chain_q <= {chain_q[6:0], bus.scan_in};
        else             chain_q <= chain_q[7:4] * chain_q[3:0];
    end
    assign bus.chain_out = chain_q[7];

    int         total = 0;
    int         bad = 0;
    int         cycle = 0;
    exp_t       sb[$];
    int         cur_accept = -1;
    logic [7:0] cur_pattern = 8'h00;
    int         free_edge = 0;
    logic [7:0] model_result = 8'h00;
    logic       model_pass = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] refResponse(input logic [7:0] p);
        logic [7:0] prod;
        prod = p[7:4] * p[3:0];
        return prod;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, cycle, actual, expected);
        end
    endtask

    // Offer one start; the model alone decides whether the controller is free to take it.
    task automatic applyStimulus(input logic [7:0] pat, input logic [7:0] exp_word);
        exp_t e;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.pattern_in = pat;
`ifdef SCAN_CTRL_COMPARE_EN
        bus.expected_in = exp_word;
`endif
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (cycle >= free_edge) begin
            cur_accept  = cycle;
            cur_pattern = pat;
            free_edge   = cycle + LAT + 1;
            e.done_edge = cycle + LAT;
            e.res       = refResponse(pat);
            e.pass_exp  = (refResponse(pat) == exp_word);
            sb.push_back(e);
        end
    endtask

    task automatic modelReset();
        sb.delete();
        cur_accept   = -1;
        free_edge    = 0;
        model_result = 8'h00;
        model_pass   = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_scan_in"}, 32'(bus.scan_in), 32'd0);
        checkOutput({tag, "_scan_en"}, 32'(bus.scan_en), 32'd0);
        checkOutput({tag, "_busy"},    32'(bus.busy),    32'd0);
        checkOutput({tag, "_done"},    32'(bus.done),    32'd0);
        checkOutput({tag, "_result"},  32'(bus.result),  32'd0);
`ifdef SCAN_CTRL_COMPARE_EN
        checkOutput({tag, "_pass"},    32'(bus.pass),    32'd0);
`endif
    endtask

    // Monitor: compares every visible output against the model once per cycle.
    always @(negedge clk) begin
        logic due;
        int   d;
        if (!rst) begin
            due = (sb.size() > 0) && (sb[0].done_edge == cycle);
            checkOutput("done", 32'(bus.done), 32'(due));
            if (due) begin
                model_result = sb[0].res;
                model_pass   = sb[0].pass_exp;
                sb.pop_front();
            end
            checkOutput("result", 32'(bus.result), 32'(model_result));
`ifdef SCAN_CTRL_COMPARE_EN
            checkOutput("pass", 32'(bus.pass), 32'(model_pass));
`endif
            d = (cur_accept >= 0) ? (cycle - cur_accept) : 1000;
            checkOutput("busy", 32'(bus.busy), 32'(d <= LAT - 1));
            checkOutput("scan_en", 32'(bus.scan_en), 32'((d <= N - 1) || (d >= N + 1 && d <= LAT - 1)));
            if (d <= N - 1)
                checkOutput("scan_in", 32'(bus.scan_in), 32'(cur_pattern[N-1-d]));
            else if (d >= N + 1 && d <= LAT - 1)
                checkOutput("scan_in_fill", 32'(bus.scan_in), 32'd0);
        end
    end

    initial begin
        logic [7:0] p;
        logic [7:0] e;
        bus.start      = 1'b0;
        bus.pattern_in = 8'h00;
`ifdef SCAN_CTRL_COMPARE_EN
        bus.expected_in = 8'h00;
`endif
        // Reset state and idle hold.
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] all-ones pattern");
        applyStimulus(8'hFF, 8'hE1);
        repeat (LAT + 2) @(posedge clk);

        $display("[TB] pattern 0x23");
        applyStimulus(8'h23, 8'h06);
        repeat (LAT + 2) @(posedge clk);

        $display("[TB] start while busy, then start in the done cycle");
        applyStimulus(8'h23, 8'h06);
        repeat (4) @(posedge clk);
        applyStimulus(8'h11, 8'h00);
        repeat (12) @(posedge clk);
        applyStimulus(8'h32, 8'h06);
        repeat (LAT + 2) @(posedge clk);

        $display("[TB] async reset during shift-out");
        applyStimulus(8'hFF, 8'hE1);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkAllZero("abort");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        applyStimulus(8'hFF, 8'hE1);
        repeat (LAT + 2) @(posedge clk);

`ifdef SCAN_CTRL_COMPARE_EN
        $display("[TB] compare mode");
        applyStimulus(8'hFF, 8'hE1);
        repeat (LAT + 2) @(posedge clk);
        applyStimulus(8'hFF, 8'h00);
        repeat (LAT + 2) @(posedge clk);
`endif

        $display("[TB] randomized starts");
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            p = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? refResponse(p) : 8'($urandom);
            applyStimulus(p, e);
        end

        while (cycle < free_edge + 2) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
